// File: rtl/game_pkg.sv
// Shared types and constants for the symbol-counting game.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNTDOWN,
    ST_GENERATE,
    ST_ANSWER,
    ST_SCORE,
    ST_DONE
  } round_state_t;

  localparam int COUNT_W = 8;
  localparam int SCORE_W = 4;
  localparam int ROUND_W = 4;

  // Width of the second counters (generation window, answer timeout).
  localparam int SEC_W = 8;

  // Default second counts, shared with the answer-period block.
  localparam int DEF_COUNTDOWN_SECONDS = 3;
  localparam int DEF_GEN_SECONDS       = 10;
  localparam int DEF_ANSWER_TIMEOUT    = 8;

  // Score increment that sticks at the all-ones maximum.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sec_down_counter.sv
// Loadable seconds down-counter; decrements on tick, stops at zero.
module sec_down_counter
  import game_pkg::*;
#(
  parameter int W = SEC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick_en,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_q, count_d;

  // Next count: load has priority over a tick.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (tick_en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/round_controller.sv
// Game sequencer: countdown, generation window, answer period and scoring
// for a fixed number of rounds, all paced by a 1 Hz tick.
module round_controller
  import game_pkg::*;
#(
  parameter int NUM_ROUNDS        = 5,
  parameter int COUNTDOWN_SECONDS = DEF_COUNTDOWN_SECONDS,
  parameter int GEN_SECONDS       = DEF_GEN_SECONDS,
  parameter int ANSWER_TIMEOUT    = DEF_ANSWER_TIMEOUT
) (
  input  logic               Clk100M,
  input  logic               Reset,
  input  logic               tick1Hz,
  input  logic               startBtn,
  input  logic               postSig,
  input  logic [COUNT_W-1:0] userCount,
  input  logic [COUNT_W-1:0] targetCount,
  output logic               genEnable,
  output logic               clearCounts,
  output logic               answerSig,
  output logic [3:0]         countdown,
  output logic [ROUND_W-1:0] roundNum,
  output logic [SCORE_W-1:0] score,
  output logic               resultValid,
  output logic               correct,
  output logic               gameOver
);

  localparam logic [3:0]         CD_LOAD   = 4'(COUNTDOWN_SECONDS);
  localparam logic [SEC_W-1:0]   GEN_LOAD  = SEC_W'(GEN_SECONDS);
  localparam logic [SEC_W-1:0]   TO_LOAD   = SEC_W'(ANSWER_TIMEOUT);
  localparam logic [ROUND_W-1:0] LAST_RND  = ROUND_W'(NUM_ROUNDS);

  round_state_t state_q, state_d;

  logic               btn_prev_q, btn_prev_d;
  logic               start_q, start_d;
  logic [3:0]         countdown_q, countdown_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               gen_q, gen_d;
  logic               clear_q, clear_d;
  logic               answer_q, answer_d;
  logic               result_q, result_d;
  logic               correct_q, correct_d;
  logic               over_q, over_d;

  logic               cnt_load;
  logic [SEC_W-1:0]   cnt_val;
  logic               cnt_tick;
  logic [SEC_W-1:0]   cnt_count;
  logic               cnt_zero;
  logic               cnt_expire;

  // One counter serves both the generation window and the answer timeout;
  // it is reloaded on entry to each of those states.
  sec_down_counter #(.W(SEC_W)) u_sec_cnt (
    .clk      (Clk100M),
    .rst      (Reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .tick_en  (cnt_tick),
    .count    (cnt_count),
    .zero     (cnt_zero)
  );

  assign cnt_tick   = tick1Hz && ((state_q == ST_GENERATE) || (state_q == ST_ANSWER));
  assign cnt_expire = cnt_tick && (cnt_zero || (cnt_count == SEC_W'(1)));

  // Next-state and registered-output computation for the round sequencer.
  always_comb begin
    state_d     = state_q;
    btn_prev_d  = startBtn;
    start_d     = startBtn && !btn_prev_q;
    countdown_d = countdown_q;
    round_d     = round_q;
    score_d     = score_q;
    correct_d   = correct_q;
    clear_d     = 1'b0;
    answer_d    = 1'b0;
    result_d    = 1'b0;
    cnt_load    = 1'b0;
    cnt_val     = '0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_q) begin
          state_d     = ST_COUNTDOWN;
          score_d     = '0;
          round_d     = ROUND_W'(1);
          countdown_d = CD_LOAD;
          clear_d     = 1'b1;
        end
      end
      ST_COUNTDOWN: begin
        if (tick1Hz) begin
          if (countdown_q <= 4'd1) begin
            state_d     = ST_GENERATE;
            countdown_d = '0;
            cnt_load    = 1'b1;
            cnt_val     = GEN_LOAD;
          end else begin
            countdown_d = countdown_q - 1'b1;
          end
        end
      end
      ST_GENERATE: begin
        if (cnt_expire) begin
          state_d  = ST_ANSWER;
          answer_d = 1'b1;
          cnt_load = 1'b1;
          cnt_val  = TO_LOAD;
        end
      end
      ST_ANSWER: begin
        // postSig and an expiring tick together still give a single SCORE.
        if (postSig || cnt_expire) begin
          state_d = ST_SCORE;
        end
      end
      ST_SCORE: begin
        correct_d = (userCount == targetCount);
        result_d  = 1'b1;
        if (userCount == targetCount) begin
          score_d = sat_inc(score_q);
        end
        if (round_q == LAST_RND) begin
          state_d = ST_DONE;
        end else begin
          state_d     = ST_COUNTDOWN;
          round_d     = round_q + 1'b1;
          countdown_d = CD_LOAD;
          clear_d     = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    gen_d  = (state_d == ST_GENERATE);
    over_d = (state_d == ST_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk100M) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      btn_prev_q  <= 1'b0;
      start_q     <= 1'b0;
      countdown_q <= '0;
      round_q     <= '0;
      score_q     <= '0;
      gen_q       <= 1'b0;
      clear_q     <= 1'b0;
      answer_q    <= 1'b0;
      result_q    <= 1'b0;
      correct_q   <= 1'b0;
      over_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      btn_prev_q  <= btn_prev_d;
      start_q     <= start_d;
      countdown_q <= countdown_d;
      round_q     <= round_d;
      score_q     <= score_d;
      gen_q       <= gen_d;
      clear_q     <= clear_d;
      answer_q    <= answer_d;
      result_q    <= result_d;
      correct_q   <= correct_d;
      over_q      <= over_d;
    end
  end

  assign genEnable   = gen_q;
  assign clearCounts = clear_q;
  assign answerSig   = answer_q;
  assign countdown   = countdown_q;
  assign roundNum    = round_q;
  assign score       = score_q;
  assign resultValid = result_q;
  assign correct     = correct_q;
  assign gameOver    = over_q;

endmodule

// File: tb/tb_round_controller.sv
// Randomized scoreboard bench for round_controller.
module tb_round_controller;

  localparam int NR = 15;
  localparam int CD = 3;
  localparam int GS = 2;
  localparam int TO = 8;

  logic       Clk100M = 1'b0;
  logic       Reset, tick1Hz, startBtn, postSig;
  logic [7:0] userCount, targetCount;
  logic       genEnable, clearCounts, answerSig, resultValid, correct, gameOver;
  logic [3:0] countdown, roundNum, score;

  always #5 Clk100M = ~Clk100M;

  round_controller #(
    .NUM_ROUNDS        (NR),
    .COUNTDOWN_SECONDS (CD),
    .GEN_SECONDS       (GS),
    .ANSWER_TIMEOUT    (TO)
  ) dut (
    .Clk100M     (Clk100M),
    .Reset       (Reset),
    .tick1Hz     (tick1Hz),
    .startBtn    (startBtn),
    .postSig     (postSig),
    .userCount   (userCount),
    .targetCount (targetCount),
    .genEnable   (genEnable),
    .clearCounts (clearCounts),
    .answerSig   (answerSig),
    .countdown   (countdown),
    .roundNum    (roundNum),
    .score       (score),
    .resultValid (resultValid),
    .correct     (correct),
    .gameOver    (gameOver)
  );

  typedef struct {
    bit correct;
    int score;
    int round;
    bit over;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  int checks = 0;
  int passes = 0;
  int results_seen = 0;
  int answers_seen = 0;
  int clears_seen = 0;
  int rounds_run = 0;
  int tick_gap = 2;
  int m_score = 0;
  int m_round = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Advance one cycle; inputs change #1 after the edge. Ticks are spaced 4..7 cycles.
  task automatic step();
    @(posedge Clk100M);
    #1;
    postSig = 1'b0;
    if (tick_gap == 0) begin
      tick1Hz  = 1'b1;
      tick_gap = $urandom_range(3, 6);
    end else begin
      tick1Hz  = 1'b0;
      tick_gap = tick_gap - 1;
    end
  endtask

  // Monitor: pops the scoreboard whenever a result is presented.
  always @(negedge Clk100M) begin
    if (answerSig) answers_seen++;
    if (clearCounts) clears_seen++;
    if (resultValid) begin
      results_seen++;
      if (sb_q.size() == 0) begin
        chk("unexpected_result", int'(resultValid), 0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("correct", int'(correct), int'(mon_e.correct));
        chk("score", int'(score), mon_e.score);
        chk("roundNum", int'(roundNum), mon_e.round);
        chk("gameOver", int'(gameOver), int'(mon_e.over));
      end
    end
  end

  task automatic start_game();
    int n;
    startBtn = 1'b0;
    step();
    startBtn = 1'b1;
    n = 0;
    while (!clearCounts && n < 10) begin
      step();
      n++;
    end
    chk("start_latency", n, 2);
    chk("score_cleared", int'(score), 0);
    m_score = 0;
    m_round = 1;
  endtask

  // mode 0: postSig before timeout, 1: timeout, 2: postSig on the expiring tick
  task automatic run_round(input int mode, input logic [7:0] uc, input logic [7:0] tc);
    int n, tcnt, a, p;
    bit t, fin;
    exp_t e;
    n = 0;
    while (!clearCounts && n < 10) begin
      step();
      n++;
    end
    chk("clearCounts_seen", int'(clearCounts), 1);
    chk("countdown_load", int'(countdown), CD);
    chk("roundNum_entry", int'(roundNum), m_round);
    // Countdown seconds
    tcnt = 0;
    n = 0;
    while (tcnt < CD && n < 100) begin
      t = tick1Hz;
      step();
      n++;
      if (t) begin
        tcnt++;
        if (tcnt < CD) chk("countdown_dec", int'(countdown), CD - tcnt);
        else begin
          chk("countdown_zero", int'(countdown), 0);
          chk("genEnable_on", int'(genEnable), 1);
        end
      end
    end
    chk("countdown_ticks", tcnt, CD);
    // Generation window; stray postSig and a startBtn edge must be ignored
    postSig  = 1'b1;
    startBtn = ~startBtn;
    tcnt = 0;
    n = 0;
    while (tcnt < GS && n < 100) begin
      t = tick1Hz;
      step();
      n++;
      if (t) begin
        tcnt++;
        if (tcnt < GS) chk("genEnable_hold", int'(genEnable), 1);
      end
    end
    chk("gen_ticks", tcnt, GS);
    chk("genEnable_off", int'(genEnable), 0);
    chk("answerSig", int'(answerSig), 1);
    // Answer period
    userCount   = uc;
    targetCount = tc;
    p = $urandom_range(0, TO - 2);
    a = 0;
    fin = 0;
    n = 0;
    while (!fin && n < 200) begin
      t = tick1Hz;
      if (mode == 0 && a == p) begin
        postSig = 1'b1;
        fin = 1;
      end
      if (t && a == TO - 1) begin
        fin = 1;
        if (mode == 2) postSig = 1'b1;
      end
      if (t) a++;
      step();
      n++;
    end
    chk("answer_end", int'(fin), 1);
    e.correct = (uc == tc);
    if (uc == tc && m_score < 15) m_score++;
    e.score = m_score;
    e.over  = (m_round == NR);
    e.round = e.over ? m_round : m_round + 1;
    sb_q.push_back(e);
    m_round = e.round;
    rounds_run++;
    chk("result_not_early", int'(resultValid), 0);
    step();
    chk("result_latency", int'(resultValid), 1);
  endtask

  task automatic hold_done();
    repeat (30) begin
      if ($urandom_range(0, 3) == 0) postSig = 1'b1;
      step();
    end
    chk("done_gameOver", int'(gameOver), 1);
    chk("done_score", int'(score), m_score);
    chk("done_round", int'(roundNum), NR);
    chk("done_genEnable", int'(genEnable), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] u;
    int md;
    Reset = 1'b1;
    tick1Hz = 1'b0;
    startBtn = 1'b0;
    postSig = 1'b0;
    userCount = '0;
    targetCount = '0;
    repeat (3) step();
    chk("rst_roundNum", int'(roundNum), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_countdown", int'(countdown), 0);
    chk("rst_outputs", int'({genEnable, clearCounts, answerSig, resultValid, correct, gameOver}), 0);
    Reset = 1'b0;
    repeat (10) step();
    chk("idle_roundNum", int'(roundNum), 0);

    // Game A: directed opening rounds, then random
    start_game();
    run_round(0, 8'd12, 8'd12);
    run_round(0, 8'd7, 8'd9);
    u = 8'($urandom);
    run_round(1, u, u);
    u = 8'($urandom);
    run_round(2, u, ($urandom_range(0, 1) != 0) ? u : u ^ 8'h5a);
    for (int r = 5; r <= NR; r++) begin
      md = $urandom_range(0, 2);
      u  = 8'($urandom);
      run_round(md, u, ($urandom_range(0, 1) != 0) ? u : u + 8'($urandom_range(1, 255)));
    end
    hold_done();

    // Game B from DONE: every answer right, score ends at the 15 ceiling
    start_game();
    for (int r = 1; r <= NR; r++) begin
      md = $urandom_range(0, 2);
      u  = 8'($urandom);
      run_round(md, u, u);
    end
    hold_done();
    chk("score_ceiling", m_score, 15);

    // Game C: reset in the middle of the generation window
    start_game();
    begin
      int n;
      n = 0;
      while (!genEnable && n < 100) begin
        step();
        n++;
      end
      chk("reached_generate", int'(genEnable), 1);
    end
    startBtn = 1'b0;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("midrst_genEnable", int'(genEnable), 0);
    chk("midrst_score", int'(score), 0);
    chk("midrst_roundNum", int'(roundNum), 0);
    chk("midrst_pulses", int'({clearCounts, answerSig, resultValid, gameOver}), 0);
    repeat (20) step();
    chk("idle_after_rst_round", int'(roundNum), 0);
    chk("idle_after_rst_gen", int'(genEnable), 0);
    chk("idle_after_rst_cd", int'(countdown), 0);

    chk("answer_pulses", answers_seen, rounds_run);
    chk("clear_pulses", clears_seen, rounds_run + 1);
    chk("results_seen", results_seen, rounds_run);
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
